oram_client: RTL and testbench

Request initiator for the `oram_module` access port. Accepts host commands (read/write of one block) over a valid/ready channel and buffers them in a small FIFO. Issues them one at a time to the ORAM using its `input_ready`/`output_ready` protocol, and returns each result to the host over a second valid/ready channel. Sits between the core's load/store path and the ORAM, and owns all handshake sequencing on the ORAM side.

---
 rtl/oram_client.sv | 156 +++++++++++++++
 tb/tb_oram_client.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oram_client.sv
// oram_client: buffers host block read/write commands and issues them one at a time to the ORAM.
// Optional WAIT-state timeout is compiled in when ORAM_CLIENT_TIMEOUT_EN is defined.
module oram_client #(
    parameter int D          = 6,
    parameter int A          = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic           cmd_rw,
    input  logic [D-1:0]   cmd_block,
    input  logic [8*A-1:0] cmd_wdata,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [8*A-1:0] rsp_rdata,
    output logic           rsp_rw,
    output logic           rsp_err,
    output logic           busy,
    output logic [D-1:0]   rw_block_number,
    output logic [8*A-1:0] w_value,
    output logic           rw_indicator,
    output logic           input_ready,
    input  logic [8*A-1:0] r_value,
    input  logic           output_ready
);
    localparam int DW = 8 * A;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
        $error("oram_client: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          r_state;
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic            r_fifo_rw  [FIFO_DEPTH];
    logic [D-1:0]    r_fifo_blk [FIFO_DEPTH];
    logic [DW-1:0]   r_fifo_dat [FIFO_DEPTH];

    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_count_nxt;
    logic            w_nonempty_nxt;

`ifdef ORAM_CLIENT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]   r_tmo;
`endif

    assign w_push         = cmd_valid && cmd_ready;
    assign w_pop          = (r_state == IDLE) && (r_count != '0);
    assign w_count_nxt    = r_count + CW'(w_push) - CW'(w_pop);
    assign w_nonempty_nxt = (w_count_nxt != '0);

    // Storage needs no reset: only entries below r_count are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rw[r_wptr]  <= cmd_rw;
            r_fifo_blk[r_wptr] <= cmd_block;
            r_fifo_dat[r_wptr] <= cmd_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            cmd_ready <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            r_count   <= w_count_nxt;
            cmd_ready <= (w_count_nxt != CW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= '0;
            rsp_rw          <= 1'b0;
            rsp_err         <= 1'b0;
            busy            <= 1'b0;
            input_ready     <= 1'b0;
            rw_block_number <= '0;
            w_value         <= '0;
            rw_indicator    <= 1'b0;
`ifdef ORAM_CLIENT_TIMEOUT_EN
            r_tmo           <= '0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        rw_block_number <= r_fifo_blk[r_rptr];
                        w_value         <= r_fifo_dat[r_rptr];
                        rw_indicator    <= r_fifo_rw[r_rptr];
                        input_ready     <= 1'b1;
`ifdef ORAM_CLIENT_TIMEOUT_EN
                        r_tmo           <= '0;
`endif
                        r_state         <= WAIT;
                        busy            <= 1'b1;
                    end else begin
                        busy <= w_nonempty_nxt;
                    end
                end
                WAIT: begin
                    input_ready <= 1'b0;
                    busy        <= 1'b1;
                    // A completion in the timeout cycle still counts as success.
                    if (output_ready) begin
                        rsp_rdata <= rw_indicator ? '0 : r_value;
                        rsp_rw    <= rw_indicator;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        r_state   <= RESP;
                    end
`ifdef ORAM_CLIENT_TIMEOUT_EN
                    else if (r_tmo == TW'(TIMEOUT)) begin
                        rsp_rdata <= '0;
                        rsp_rw    <= rw_indicator;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        r_state   <= RESP;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= IDLE;
                        busy      <= w_nonempty_nxt;
                    end else begin
                        busy <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oram_client.sv
// Directed bench for oram_client against a small behavioural ORAM model.
// Build with ORAM_CLIENT_TIMEOUT_EN defined to exercise the timeout path.
module tb_oram_client;
    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rw;
    logic [5:0]  cmd_block;
    logic [63:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_rw;
    logic        rsp_err;
    logic        busy;
    logic [5:0]  rw_block_number;
    logic [63:0] w_value;
    logic        rw_indicator;
    logic        input_ready;
    logic [63:0] r_value;
    logic        output_ready;

    oram_client #(.D(6), .A(8), .FIFO_DEPTH(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_block(cmd_block), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_rw(rsp_rw), .rsp_err(rsp_err), .busy(busy),
        .rw_block_number(rw_block_number), .w_value(w_value),
        .rw_indicator(rw_indicator), .input_ready(input_ready),
        .r_value(r_value), .output_ready(output_ready)
    );

    typedef struct { logic rw; logic [5:0] blk; logic [63:0] wd; logic [63:0] exp; } vec_t;
    typedef struct { int cyc; logic rw; logic [5:0] blk; logic [63:0] wd; } stb_t;
    typedef struct { int cyc; int orc; logic [63:0] rd; logic rw; logic err; } rsp_t;

    int   nerr = 0;
    int   nchk = 0;
    int   cyc  = 0;
    int   or_cyc = 0;
    stb_t sq[$];
    rsp_t rq[$];

    logic stall, deaf, stray;
    int   lat;

    // ORAM model: completes lat cycles after the input_ready strobe.
    logic [63:0] mem [int];
    logic        m_pend;
    logic        m_rw;
    logic [5:0]  m_blk;
    logic [63:0] m_wd;
    int          m_cnt;
    logic        m_or;
    assign output_ready = m_or | stray;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        m_or <= 1'b0;
        if (!rst_n) begin
            m_pend = 1'b0;
        end else if (input_ready && !deaf) begin
            m_pend = 1'b1;
            m_cnt  = lat - 1;
            m_rw   = rw_indicator;
            m_blk  = rw_block_number;
            m_wd   = w_value;
        end else if (m_pend && !stall) begin
            if (m_cnt <= 1) begin
                m_or   <= 1'b1;
                m_pend = 1'b0;
                if (m_rw) begin
                    mem[int'(m_blk)] = m_wd;
                    r_value <= 64'hBAD0_BAD0_BAD0_BAD0;
                end else begin
                    r_value <= mem.exists(int'(m_blk)) ? mem[int'(m_blk)] : 64'h0;
                end
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (input_ready)
            sq.push_back('{cyc, rw_indicator, rw_block_number, w_value});
        if (output_ready)
            or_cyc = cyc;
        if (rsp_valid && rsp_ready)
            rq.push_back('{cyc, or_cyc, rsp_rdata, rsp_rw, rsp_err});
    end

    logic [140:0] w_outs;
    assign w_outs = {cmd_ready, rsp_valid, rsp_rdata, rsp_rw, rsp_err, busy,
                     input_ready, rw_block_number, w_value, rw_indicator};

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic rw, input logic [5:0] blk, input logic [63:0] wd,
                        output int acc);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_block = blk;
        cmd_wdata = wd;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("send_accept", cmd_ready, 1);
            cmd_valid = 1'b0;
            acc = -1;
        end else begin
            @(posedge clk);
            #1;
            acc = cyc - 1;
            cmd_valid = 1'b0;
        end
    endtask

    task automatic get_rsp(output rsp_t r);
        int n = 0;
        while (rq.size() == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_present", rq.size() != 0, 1);
        if (rq.size() != 0) r = rq.pop_front();
        else r = '{0, 0, 64'h0, 1'b0, 1'b0};
    endtask

    task automatic pop_stb(output stb_t s);
        chk("strobe_present", sq.size() != 0, 1);
        if (sq.size() != 0) s = sq.pop_front();
        else s = '{0, 1'b0, 6'h0, 64'h0};
    endtask

    vec_t vt[8];
    vec_t fv[6];
    int   acc[6];
    rsp_t r, r2;
    stb_t s, s2, s3;
    logic [65:0] p;
    logic stable;
    int   rel, n;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_block = '0; cmd_wdata = '0;
        rsp_ready = 1'b1; stall = 1'b0; deaf = 1'b0; stray = 1'b0; lat = 4;
        m_or = 1'b0; r_value = '0; m_pend = 1'b0;

        vt[0] = '{1'b1, 6'h05, 64'h1122334455667788, 64'h0};
        vt[1] = '{1'b0, 6'h05, 64'h0,                64'h1122334455667788};
        vt[2] = '{1'b1, 6'h3F, 64'hDEADBEEFCAFEF00D, 64'h0};
        vt[3] = '{1'b0, 6'h3F, 64'h0,                64'hDEADBEEFCAFEF00D};
        vt[4] = '{1'b0, 6'h00, 64'h0,                64'h0};
        vt[5] = '{1'b1, 6'h00, 64'hFFFFFFFFFFFFFFFF, 64'h0};
        vt[6] = '{1'b0, 6'h00, 64'h0,                64'hFFFFFFFFFFFFFFFF};
        vt[7] = '{1'b0, 6'h05, 64'h0,                64'h1122334455667788};

        fv[0] = '{1'b1, 6'h10, 64'hA5A5A5A500000001, 64'h0};
        fv[1] = '{1'b0, 6'h10, 64'h0,                64'hA5A5A5A500000001};
        fv[2] = '{1'b1, 6'h11, 64'h0123456789ABCDEF, 64'h0};
        fv[3] = '{1'b0, 6'h11, 64'h0,                64'h0123456789ABCDEF};
        fv[4] = '{1'b0, 6'h05, 64'h0,                64'h1122334455667788};
        fv[5] = '{1'b0, 6'h10, 64'h0,                64'hA5A5A5A500000001};

        // Reset state and first-cycle cmd_ready
        repeat (2) @(negedge clk);
        chk("reset_outs", w_outs, 0);
        rst_n = 1'b1;
        chk("cmd_ready_before_edge", cmd_ready, 0);
        @(negedge clk);
        chk("cmd_ready_rise", cmd_ready, 1);
        chk("idle_busy", busy, 0);

        // Table: one command at a time from an empty, idle client
        for (int i = 0; i < 8; i++) begin
            send(vt[i].rw, vt[i].blk, vt[i].wd, acc[0]);
            get_rsp(r);
            pop_stb(s);
            chk($sformatf("v%0d_strobe_cycle", i), s.cyc, acc[0] + 2);
            chk($sformatf("v%0d_strobe_single", i), sq.size(), 0);
            chk($sformatf("v%0d_oram_rw", i), s.rw, vt[i].rw);
            chk($sformatf("v%0d_oram_blk", i), s.blk, vt[i].blk);
            if (vt[i].rw) chk($sformatf("v%0d_oram_wdata", i), s.wd, vt[i].wd);
            chk($sformatf("v%0d_rdata", i), r.rd, vt[i].exp);
            chk($sformatf("v%0d_rsp_rw", i), r.rw, vt[i].rw);
            chk($sformatf("v%0d_rsp_err", i), r.err, 0);
            chk($sformatf("v%0d_rsp_after_or", i), r.cyc, r.orc + 1);
            chk($sformatf("v%0d_latency", i), r.cyc, s.cyc + 5);
        end

        // Back-to-back strobes with rsp_ready held high
        sq.delete(); rq.delete();
        send(1'b0, 6'h05, 64'h0, acc[0]);
        send(1'b0, 6'h3F, 64'h0, acc[1]);
        send(1'b0, 6'h00, 64'h0, acc[2]);
        get_rsp(r);
        chk("b2b_rsp0", r.rd, 64'h1122334455667788);
        get_rsp(r);
        chk("b2b_rsp1", r.rd, 64'hDEADBEEFCAFEF00D);
        get_rsp(r);
        chk("b2b_rsp2", r.rd, 64'hFFFFFFFFFFFFFFFF);
        pop_stb(s); pop_stb(s2); pop_stb(s3);
        chk("b2b_gap01", s2.cyc - s.cyc, 7);
        chk("b2b_gap12", s3.cyc - s2.cyc, 7);

        // FIFO full: one in flight plus four buffered
        sq.delete(); rq.delete();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) send(fv[i].rw, fv[i].blk, fv[i].wd, acc[i]);
        @(negedge clk);
        chk("fifo_full_ready", cmd_ready, 0);
        chk("fifo_full_busy", busy, 1);
        fork
            send(fv[5].rw, fv[5].blk, fv[5].wd, acc[5]);
            begin
                repeat (4) @(negedge clk);
                chk("fifo_full_hold", cmd_ready, 0);
                stall = 1'b0;
            end
        join
        for (int i = 0; i < 6; i++) begin
            get_rsp(r);
            pop_stb(s);
            chk($sformatf("fifo%0d_rdata", i), r.rd, fv[i].exp);
            chk($sformatf("fifo%0d_blk", i), s.blk, fv[i].blk);
            if (i == 1) chk("fifo_accept_after_pop", acc[5], s.cyc);
        end

        // Response backpressure
        sq.delete(); rq.delete();
        @(posedge clk); #1 rsp_ready = 1'b0;
        send(1'b0, 6'h3F, 64'h0, acc[0]);
        send(1'b0, 6'h05, 64'h0, acc[1]);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid", rsp_valid, 1);
        p = {rsp_rdata, rsp_rw, rsp_err};
        chk("bp_payload", p, {64'hDEADBEEFCAFEF00D, 1'b0, 1'b0});
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!rsp_valid || {rsp_rdata, rsp_rw, rsp_err} !== p) stable = 1'b0;
        end
        chk("bp_stable", stable, 1);
        chk("bp_no_issue", sq.size(), 1);
        @(posedge clk); #1 rsp_ready = 1'b1;
        rel = cyc;
        get_rsp(r);
        get_rsp(r2);
        chk("bp_rsp0", r.rd, 64'hDEADBEEFCAFEF00D);
        chk("bp_rsp1", r2.rd, 64'h1122334455667788);
        pop_stb(s); pop_stb(s2);
        chk("bp_next_issue", s2.cyc, rel + 2);

        sq.delete(); rq.delete();
`ifdef ORAM_CLIENT_TIMEOUT_EN
        // Timeout: ORAM never answers
        deaf = 1'b1;
        send(1'b0, 6'h05, 64'h0, acc[0]);
        get_rsp(r);
        pop_stb(s);
        chk("tmo_err", r.err, 1);
        chk("tmo_rdata", r.rd, 0);
        chk("tmo_cycle", r.cyc, s.cyc + 9);
        deaf = 1'b0;
        send(1'b0, 6'h05, 64'h0, acc[0]);
        get_rsp(r);
        pop_stb(s);
        chk("tmo_next_strobe", s.cyc, acc[0] + 2);
        chk("tmo_next_err", r.err, 0);
        chk("tmo_next_rdata", r.rd, 64'h1122334455667788);
        deaf = 1'b1;
        send(1'b0, 6'h05, 64'h0, acc[0]);
`else
        // Without the timeout WAIT persists
        deaf = 1'b1;
        send(1'b0, 6'h05, 64'h0, acc[0]);
        repeat (40) @(negedge clk);
        chk("wait_forever_norsp", rq.size(), 0);
        chk("wait_forever_busy", busy, 1);
`endif
        // Reset mid-WAIT with two commands buffered
        send(1'b0, 6'h3F, 64'h0, acc[1]);
        send(1'b1, 6'h3F, 64'h5555, acc[2]);
        repeat (2) @(negedge clk);
        chk("prereset_busy", busy, 1);
        chk("prereset_norsp", rq.size(), 0);
        #2 rst_n = 1'b0;
        #1 chk("reset_async_outs", w_outs, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sq.delete(); rq.delete();
        deaf = 1'b0;
        repeat (20) @(negedge clk);
        chk("postreset_norsp", rq.size(), 0);
        chk("postreset_noissue", sq.size(), 0);
        chk("postreset_busy", busy, 0);
        chk("postreset_ready", cmd_ready, 1);

        // Stray output_ready in IDLE
        @(negedge clk); stray = 1'b1;
        @(negedge clk); stray = 1'b0;
        repeat (5) @(negedge clk);
        chk("stray_norsp", {rsp_valid, rq.size() != 0}, 0);
        send(1'b0, 6'h3F, 64'h0, acc[0]);
        get_rsp(r);
        chk("stray_after_read", r.rd, 64'hDEADBEEFCAFEF00D);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
